unidade_controle_multiciclo: RTL and testbench
==============================================

Name: unidade_controle_multiciclo

Overview:
- Multicycle FSM controller that sequences the shared RISC-V datapath: ALU, register file, single unified memory port, PC and instruction register (IR).
- Supports R-type, lw, sw, beq and the all-zero opcode, which is a NOP.
- Handshakes with the memory via a ready strobe and includes a memory timeout watchdog.
- Any unsupported opcode or memory timeout moves the FSM to a sticky error state.

Parameters:
- TIMEOUT_MEM, 15: max cycles waiting for mem_pronta in a memory state before error; 0 disables the watchdog.
- LARG_CONT, 4: width of the wait counter; must satisfy 2^LARG_CONT > TIMEOUT_MEM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  7  IR[6:0]; valid from DECODIFICA onward.
- mem_pronta  in  1  memory completed the current read/write this cycle.
- escrevePC  out  1  PC load enable (unconditional).
- escreveIR  out  1  IR and PC_antigo load enable.
- louD  out  1  memory address select: 0=PC, 1=ALUOut.
- leMem  out  1  memory read request.
- escreveMem  out  1  memory write request.
- escreveReg  out  1  register file write enable.
- enviaMemParaReg  out  1  writeback select: 1=MDR, 0=ALUOut.
- ALUSrcA  out  2  ALU A input: 00=PC, 01=rs1, 10=PC_antigo.
- ALUSrcB  out  2  ALU B input: 00=rs2, 01=constant 4, 10=immediate.
- codigoALU  out  2  00=add, 01=sub/compare, 10=decode funct.
- sinalBranch  out  1  PC conditional write; the datapath ANDs it with the zero flag.
- fontePC  out  1  PC source: 0=ALU result, 1=ALUOut.
- instr_concluida  out  1  one-cycle pulse on the final cycle of each instruction.
- erro  out  1  sticky error flag.
- causa_erro  out  2  00=none, 01=illegal opcode, 10=memory timeout.
- estado  out  4  current state, for debug.

Behaviour:
- Reset: state=BUSCA, wait counter=0, erro=0, causa_erro=00.
  - While reset=1, escrevePC, escreveIR, escreveMem, escreveReg, sinalBranch and instr_concluida are forced 0.
  - Reset taken mid-operation aborts the instruction. No write strobe is asserted in the reset cycle.
- Outputs are decoded from the state (Moore). The exceptions are escrevePC/escreveIR in BUSCA, which are gated by mem_pronta (Mealy).
- Any signal not listed for a state is 0.
- States (encoding 0..9):
  - BUSCA(0): leMem=1, louD=0, ALUSrcA=00, ALUSrcB=01, codigoALU=00, fontePC=0.
    - escreveIR and escrevePC equal mem_pronta.
    - mem_pronta=1 -> DECODIFICA; otherwise stay.
  - DECODIFICA(1): ALUSrcA=10, ALUSrcB=10, codigoALU=00; computes the branch target into ALUOut.
    - Transitions by opcode:
      - 0110011 -> EXEC_R.
      - 0000011 or 0100011 -> CALC_END.
      - 1100011 -> BRANCH.
      - 0000000 -> BUSCA, with instr_concluida=1.
      - any other opcode -> ERRO, causa_erro=01.
  - CALC_END(2): ALUSrcA=01, ALUSrcB=10, codigoALU=00. Next state: LE_MEM for lw, else ESCREVE_MEM.
  - LE_MEM(3): leMem=1, louD=1. mem_pronta=1 -> ESCRITA_LW.
  - ESCRITA_LW(4): escreveReg=1, enviaMemParaReg=1, instr_concluida=1 -> BUSCA.
  - ESCREVE_MEM(5): escreveMem=1, louD=1. mem_pronta=1 -> BUSCA, with instr_concluida=1 in that cycle.
  - EXEC_R(6): ALUSrcA=01, ALUSrcB=00, codigoALU=10 -> ESCRITA_R.
  - ESCRITA_R(7): escreveReg=1, enviaMemParaReg=0, instr_concluida=1 -> BUSCA.
  - BRANCH(8): ALUSrcA=01, ALUSrcB=00, codigoALU=01, sinalBranch=1, fontePC=1, instr_concluida=1 -> BUSCA.
  - ERRO(9): all strobes 0, erro=1. The state is held until reset.
- Watchdog:
  - Counter increments each cycle spent in BUSCA, LE_MEM or ESCREVE_MEM with mem_pronta=0.
  - It clears on every state change and whenever mem_pronta=1.
  - If the counter equals TIMEOUT_MEM while mem_pronta=0 and TIMEOUT_MEM≠0: next state is ERRO, causa_erro=10.
  - If mem_pronta=1 in that same cycle, the memory completion wins.
- Latency in cycles with zero-wait memory: R=4, lw=5, sw=4, beq=3, NOP=2.
- The first error cause latches and is not overwritten.

Decomposition:
- Shared package (pacote_controle):
  - opcode constants: OP_R, OP_LW, OP_SW, OP_BEQ, OP_NOP.
  - state encodings 0..9.
  - ALUSrcA/ALUSrcB/codigoALU encodings.
  - causa_erro codes.
- One sub-module: contador_espera (wait counter plus timeout compare, parameterised by TIMEOUT_MEM and LARG_CONT).
- The FSM next-state and output decode stay in unidade_controle_multiciclo.

Test Plan:
- R-type (opcode=0110011), mem_pronta=1 always:
  - estado sequence 0,1,6,7,0.
  - escreveReg=1 only in state 7.
  - instr_concluida pulses once.
  - codigoALU=10 in state 6.
- lw (0000011), mem_pronta low for 2 cycles in LE_MEM:
  - stays in state 3 for 3 cycles, then state 4 with enviaMemParaReg=1 and escreveReg=1.
  - total 7 cycles.
- sw then beq, zero-wait memory:
  - sw: escreveMem=1 for exactly 1 cycle, louD=1, returns to BUSCA after 4 cycles.
  - beq: sinalBranch=1 and fontePC=1 in state 8, codigoALU=01.
- Illegal opcode 1111111 in DECODIFICA -> estado=9, erro=1, causa_erro=01 the next cycle; all strobes 0 for 20 further cycles.
- mem_pronta held at 0 in BUSCA with TIMEOUT_MEM=15 -> ERRO entered after 16 cycles in BUSCA, causa_erro=10.
  - Repeat with mem_pronta=1 on the timeout cycle -> DECODIFICA, no error.
- reset=1 asserted in LE_MEM and in ESCREVE_MEM:
  - no escreveMem/escreveReg/escrevePC during the reset cycle.
  - estado=0, erro=0 afterwards, and normal fetch resumes.

Source files
------------

// File: rtl/unidade_controle_multiciclo_pkg.sv
// pacote_controle: opcodes, state encodings and control field codes shared by the multicycle controller
package pacote_controle;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_NOP = 7'b0000000;

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECODIFICA  = 4'd1,
        CALC_END    = 4'd2,
        LE_MEM      = 4'd3,
        ESCRITA_LW  = 4'd4,
        ESCREVE_MEM = 4'd5,
        EXEC_R      = 4'd6,
        ESCRITA_R   = 4'd7,
        BRANCH      = 4'd8,
        ERRO        = 4'd9
    } estado_t;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_PCANT  = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;
    localparam logic [1:0] CAUSA_NADA  = 2'b00;
    localparam logic [1:0] CAUSA_ILEG  = 2'b01;
    localparam logic [1:0] CAUSA_TEMPO = 2'b10;
endpackage

// File: rtl/unidade_controle_multiciclo_contador_espera.sv
// contador_espera: counts memory wait cycles and flags a timeout when the limit is reached
module contador_espera #(
    parameter int TIMEOUT_MEM = 15,
    parameter int LARG_CONT   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic conta,
    output logic estouro
);
    logic [LARG_CONT-1:0] cont;

    always_comb begin
        estouro = (TIMEOUT_MEM != 0) && conta && (cont == LARG_CONT'(TIMEOUT_MEM));
    end

    always_ff @(posedge clk) begin
        if (reset || !conta || estouro)
            cont <= '0;
        else
            cont <= cont + LARG_CONT'(1);
    end
endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle RISC-V control FSM with memory handshake and timeout watchdog
module unidade_controle_multiciclo
    import pacote_controle::*;
#(
    parameter int TIMEOUT_MEM = 15,
    parameter int LARG_CONT   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_pronta,
    output logic       escrevePC,
    output logic       escreveIR,
    output logic       louD,
    output logic       leMem,
    output logic       escreveMem,
    output logic       escreveReg,
    output logic       enviaMemParaReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] codigoALU,
    output logic       sinalBranch,
    output logic       fontePC,
    output logic       instr_concluida,
    output logic       erro,
    output logic [1:0] causa_erro,
    output logic [3:0] estado
);
    estado_t atual, proximo;
    logic    emMem, estouro;

    always_comb begin
        emMem = atual == BUSCA || atual == LE_MEM || atual == ESCREVE_MEM;
    end

    contador_espera #(.TIMEOUT_MEM(TIMEOUT_MEM), .LARG_CONT(LARG_CONT)) uEspera (
        .clk(clk),
        .reset(reset),
        .conta(emMem && !mem_pronta),
        .estouro(estouro)
    );

    always_comb begin
        proximo = atual;
        case (atual)
            BUSCA:       proximo = mem_pronta ? DECODIFICA : estouro ? ERRO : BUSCA;
            DECODIFICA:  proximo = opcode == OP_R ? EXEC_R :
                                   (opcode == OP_LW || opcode == OP_SW) ? CALC_END :
                                   opcode == OP_BEQ ? BRANCH :
                                   opcode == OP_NOP ? BUSCA : ERRO;
            CALC_END:    proximo = opcode == OP_LW ? LE_MEM : ESCREVE_MEM;
            LE_MEM:      proximo = mem_pronta ? ESCRITA_LW : estouro ? ERRO : LE_MEM;
            ESCREVE_MEM: proximo = mem_pronta ? BUSCA : estouro ? ERRO : ESCREVE_MEM;
            EXEC_R:      proximo = ESCRITA_R;
            ESCRITA_LW, ESCRITA_R, BRANCH: proximo = BUSCA;
            ERRO:        proximo = ERRO;
            default:     proximo = ERRO;
        endcase
    end

    // Write strobes are gated by reset so an aborted instruction never commits state
    always_comb begin
        estado          = atual;
        leMem           = atual == BUSCA || atual == LE_MEM;
        louD            = atual == LE_MEM || atual == ESCREVE_MEM;
        enviaMemParaReg = atual == ESCRITA_LW;
        fontePC         = atual == BRANCH;
        escrevePC       = !reset && atual == BUSCA && mem_pronta;
        escreveIR       = !reset && atual == BUSCA && mem_pronta;
        escreveMem      = !reset && atual == ESCREVE_MEM;
        escreveReg      = !reset && (atual == ESCRITA_LW || atual == ESCRITA_R);
        sinalBranch     = !reset && atual == BRANCH;
        instr_concluida = !reset && (atual == ESCRITA_LW || atual == ESCRITA_R || atual == BRANCH ||
                          (atual == ESCREVE_MEM && mem_pronta) || (atual == DECODIFICA && opcode == OP_NOP));
        ALUSrcA         = atual == DECODIFICA ? SRCA_PCANT :
                          (atual == CALC_END || atual == EXEC_R || atual == BRANCH) ? SRCA_RS1 : SRCA_PC;
        ALUSrcB         = atual == BUSCA ? SRCB_4 :
                          (atual == DECODIFICA || atual == CALC_END) ? SRCB_IMM : SRCB_RS2;
        codigoALU       = atual == EXEC_R ? ALU_FUNCT : atual == BRANCH ? ALU_SUB : ALU_ADD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            atual      <= BUSCA;
            erro       <= 1'b0;
            causa_erro <= CAUSA_NADA;
        end else begin
            atual <= proximo;
            if (!erro && proximo == ERRO) begin
                erro       <= 1'b1;
                causa_erro <= estouro ? CAUSA_TEMPO : CAUSA_ILEG;
            end
        end
    end
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: random instruction streams checked cycle by cycle through a scoreboard queue
module tb_unidade_controle_multiciclo;
    typedef struct packed {
        logic [3:0] est;
        logic pc, ir, lou, le, wm, wr, m2r;
        logic [1:0] a, b, alu;
        logic br, fpc, done, erro;
        logic [1:0] causa;
    } ctrl_t;

    logic clk = 1'b0;
    logic reset, mem_pronta;
    logic [6:0] opcode;
    logic escrevePC, escreveIR, louD, leMem, escreveMem, escreveReg, enviaMemParaReg;
    logic [1:0] ALUSrcA, ALUSrcB, codigoALU, causa_erro;
    logic sinalBranch, fontePC, instr_concluida, erro;
    logic [3:0] estado;

    int checks = 0;
    int failures = 0;
    ctrl_t q[$];
    ctrl_t expv, actv;

    localparam logic [6:0] OPS [5] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0000000};

    unidade_controle_multiciclo #(.TIMEOUT_MEM(15), .LARG_CONT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_pronta(mem_pronta),
        .escrevePC(escrevePC), .escreveIR(escreveIR), .louD(louD), .leMem(leMem),
        .escreveMem(escreveMem), .escreveReg(escreveReg), .enviaMemParaReg(enviaMemParaReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .codigoALU(codigoALU),
        .sinalBranch(sinalBranch), .fontePC(fontePC), .instr_concluida(instr_concluida),
        .erro(erro), .causa_erro(causa_erro), .estado(estado)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic logic [6:0] ilegal();
        logic [6:0] o;
        do o = rop(); while (o == 7'b0110011 || o == 7'b0000011 || o == 7'b0100011 ||
                             o == 7'b1100011 || o == 7'b0000000);
        return o;
    endfunction

    // Control values each state must present, as tabulated in the design description
    function automatic ctrl_t esperado(int st, logic mp, logic [6:0] op, logic rst, logic [1:0] causa);
        ctrl_t e;
        e = '0;
        e.est = 4'(st);
        case (st)
            0: begin e.le = 1; e.b = 2'b01; e.pc = mp; e.ir = mp; end
            1: begin e.a = 2'b10; e.b = 2'b10; e.done = (op == 7'b0); end
            2: begin e.a = 2'b01; e.b = 2'b10; end
            3: begin e.le = 1; e.lou = 1; end
            4: begin e.wr = 1; e.m2r = 1; e.done = 1; end
            5: begin e.wm = 1; e.lou = 1; e.done = mp; end
            6: begin e.a = 2'b01; e.alu = 2'b10; end
            7: begin e.wr = 1; e.done = 1; end
            8: begin e.a = 2'b01; e.alu = 2'b01; e.br = 1; e.fpc = 1; e.done = 1; end
            9: begin e.erro = 1; e.causa = causa; end
            default: ;
        endcase
        if (rst) begin e.pc = 0; e.ir = 0; e.wm = 0; e.wr = 0; e.br = 0; e.done = 0; end
        return e;
    endfunction

    task automatic ciclo(input logic mp, input logic [6:0] op, input logic rst, input int st, input logic [1:0] causa);
        @(posedge clk);
        #1;
        mem_pronta = mp;
        opcode = op;
        reset = rst;
        q.push_back(esperado(st, mp, op, rst, causa));
    endtask

    task automatic busca(input int fw);
        for (int i = 0; i < fw; i++) ciclo(1'b0, rop(), 1'b0, 0, 2'b00);
        ciclo(1'b1, rop(), 1'b0, 0, 2'b00);
    endtask

    task automatic instr(input int tipo, input int fw, input int mw);
        logic [6:0] op;
        op = OPS[tipo];
        busca(fw);
        ciclo(rb(), op, 1'b0, 1, 2'b00);
        case (tipo)
            0: begin ciclo(rb(), op, 1'b0, 6, 2'b00); ciclo(rb(), op, 1'b0, 7, 2'b00); end
            1: begin
                ciclo(rb(), op, 1'b0, 2, 2'b00);
                for (int i = 0; i < mw; i++) ciclo(1'b0, op, 1'b0, 3, 2'b00);
                ciclo(1'b1, op, 1'b0, 3, 2'b00);
                ciclo(rb(), op, 1'b0, 4, 2'b00);
            end
            2: begin
                ciclo(rb(), op, 1'b0, 2, 2'b00);
                for (int i = 0; i < mw; i++) ciclo(1'b0, op, 1'b0, 5, 2'b00);
                ciclo(1'b1, op, 1'b0, 5, 2'b00);
            end
            3: ciclo(rb(), op, 1'b0, 8, 2'b00);
            default: ;
        endcase
    endtask

    task automatic parado(input int n, input logic [1:0] causa);
        for (int i = 0; i < n; i++) ciclo(rb(), rop(), 1'b0, 9, causa);
        ciclo(rb(), rop(), 1'b1, 9, causa);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                expv = q.pop_front();
                actv = {estado, escrevePC, escreveIR, louD, leMem, escreveMem, escreveReg, enviaMemParaReg,
                        ALUSrcA, ALUSrcB, codigoALU, sinalBranch, fontePC, instr_concluida, erro, causa_erro};
                checks++;
                if (actv !== expv) begin
                    failures++;
                    $display("FAIL ctrl[%0d] actual=%h required=%h (estado %0d vs %0d)",
                             checks, actv, expv, actv.est, expv.est);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        mem_pronta = 1'b0;
        opcode = 7'b0;
        ciclo(1'b0, 7'b0, 1'b1, 0, 2'b00);
        ciclo(1'b1, rop(), 1'b1, 0, 2'b00);
        instr(0, 0, 0);
        instr(1, 0, 2);
        instr(2, 0, 0);
        instr(3, 0, 0);
        instr(4, 0, 0);
        instr(1, 1, 15);
        for (int n = 0; n < 60; n++)
            instr($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
        busca(0);
        ciclo(rb(), 7'b1111111, 1'b0, 1, 2'b00);
        parado(20, 2'b01);
        for (int n = 0; n < 3; n++) begin
            busca($urandom_range(0, 2));
            ciclo(rb(), ilegal(), 1'b0, 1, 2'b00);
            parado(3, 2'b01);
        end
        for (int i = 0; i < 16; i++) ciclo(1'b0, rop(), 1'b0, 0, 2'b00);
        parado(4, 2'b10);
        for (int i = 0; i < 15; i++) ciclo(1'b0, rop(), 1'b0, 0, 2'b00);
        ciclo(1'b1, rop(), 1'b0, 0, 2'b00);
        ciclo(rb(), 7'b0, 1'b0, 1, 2'b00);
        busca(0);
        ciclo(rb(), OPS[2], 1'b0, 1, 2'b00);
        ciclo(rb(), OPS[2], 1'b0, 2, 2'b00);
        for (int i = 0; i < 16; i++) ciclo(1'b0, OPS[2], 1'b0, 5, 2'b00);
        parado(2, 2'b10);
        busca(0);
        ciclo(rb(), OPS[1], 1'b0, 1, 2'b00);
        ciclo(rb(), OPS[1], 1'b0, 2, 2'b00);
        ciclo(1'b0, OPS[1], 1'b0, 3, 2'b00);
        ciclo(1'b1, OPS[1], 1'b1, 3, 2'b00);
        instr(0, 0, 0);
        busca(0);
        ciclo(rb(), OPS[2], 1'b0, 1, 2'b00);
        ciclo(rb(), OPS[2], 1'b0, 2, 2'b00);
        ciclo(1'b1, OPS[2], 1'b1, 5, 2'b00);
        ciclo(1'b1, rop(), 1'b1, 0, 2'b00);
        instr(1, 0, 1);
        instr(3, 2, 0);
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
